alu_arbiter: RTL and testbench

//  Shares one combinational 4-bit ALU between two requesters (e.g. two sequencer masters).

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/rr_arb2.sv | 33 +++
 rtl/alu_arbiter.sv | 121 ++++++++++++
 tb/tb_alu_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, opcodes, FSM encoding and arbitration helper for alu_arbiter
//
// Purpose : Common definitions used by alu_arbiter and rr_arb2.
// Contents: ALU_DW/ALU_IW/ALU_RW default widths, ALU opcode values (passed through,
//           never decoded here), arbiter FSM state encoding, and a two-way
//           round-robin pick function.
package alu_pkg;

    localparam int ALU_DW  = 4;
    localparam int ALU_IW  = 4;
    localparam int ALU_RW  = 8;
    localparam int ALU_LAT_DEF = 1;

    // Opcodes understood by the downstream ALU; the arbiter only forwards them.
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_MUL = 4'h5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // One-hot grant for two requesters; prio1 breaks a tie in favour of req[1].
    function automatic logic [1:0] rrPick(input logic [1:0] req, input logic prio1);
        logic [1:0] grant;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio1 ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
        return grant;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with registered priority pointer
//
// Purpose : Combinational one-hot grant between two requesters; the tie-break
//           pointer moves only when the granted request is actually taken.
// Ports   : iCLK    in  clock, rising edge
//           iRSTn   in  asynchronous reset, active low (req0 gets priority)
//           req     in  [1:0] request vector
//           advance in  grant consumed this cycle; rotate priority
//           grant   out [1:0] one-hot grant (zero when no request)
module rr_arb2
    import alu_pkg::*;
(
    input  logic       iCLK,
    input  logic       iRSTn,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // High when requester 1 wins a tie, i.e. requester 0 was served last.
    logic prio1;

    assign grant = rrPick(req, prio1);

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            prio1 <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            prio1 <= grant[0];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
//
// Purpose : Accepts {A,B,INST} commands from two requesters, drives the ALU from
//           registered operands, captures the result after ALU_LAT cycles and
//           returns it tagged with the requester ID. One op in flight at a time.
// Ports   : iCLK, iRSTn                         clock / async active-low reset
//           iREQx_VALID, oREQx_READY            command handshake per requester
//           iREQx_A, iREQx_B, iREQx_INST        command payload per requester
//           oALU_A, oALU_B, oALU_INST           registered ALU operands
//           iALU_RESULT                         ALU output
//           oRSP_VALID, iRSP_READY              response handshake
//           oRSP_ID, oRSP_RESULT                response payload
//           oBUSY                               high whenever not idle
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DW      = ALU_DW,
    parameter int IW      = ALU_IW,
    parameter int RW      = ALU_RW,
    parameter int ALU_LAT = ALU_LAT_DEF
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          iREQ0_VALID,
    output logic          oREQ0_READY,
    input  logic [DW-1:0] iREQ0_A,
    input  logic [DW-1:0] iREQ0_B,
    input  logic [IW-1:0] iREQ0_INST,
    input  logic          iREQ1_VALID,
    output logic          oREQ1_READY,
    input  logic [DW-1:0] iREQ1_A,
    input  logic [DW-1:0] iREQ1_B,
    input  logic [IW-1:0] iREQ1_INST,
    output logic [DW-1:0] oALU_A,
    output logic [DW-1:0] oALU_B,
    output logic [IW-1:0] oALU_INST,
    input  logic [RW-1:0] iALU_RESULT,
    output logic          oRSP_VALID,
    input  logic          iRSP_READY,
    output logic          oRSP_ID,
    output logic [RW-1:0] oRSP_RESULT,
    output logic          oBUSY
);

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    grant;
    logic          xfer;

    rr_arb2 u_rr_arb2 (
        .iCLK    (iCLK),
        .iRSTn   (iRSTn),
        .req     ({iREQ1_VALID, iREQ0_VALID}),
        .advance (xfer),
        .grant   (grant)
    );

    // Ready is gated by reset so nothing appears accepted while iRSTn is low.
    assign oREQ0_READY = iRSTn && (state == IDLE) && grant[0];
    assign oREQ1_READY = iRSTn && (state == IDLE) && grant[1];
    // A grant is only issued for a valid request, so ready alone marks a transfer.
    assign xfer        = oREQ0_READY || oREQ1_READY;

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state       <= IDLE;
            cnt         <= '0;
            oALU_A      <= '0;
            oALU_B      <= '0;
            oALU_INST   <= '0;
            oRSP_VALID  <= 1'b0;
            oRSP_ID     <= 1'b0;
            oRSP_RESULT <= '0;
            oBUSY       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (grant[1]) begin
                            oALU_A    <= iREQ1_A;
                            oALU_B    <= iREQ1_B;
                            oALU_INST <= iREQ1_INST;
                        end else begin
                            oALU_A    <= iREQ0_A;
                            oALU_B    <= iREQ0_B;
                            oALU_INST <= iREQ0_INST;
                        end
                        oRSP_ID <= grant[1];
                        cnt     <= CW'(ALU_LAT - 1);
                        oBUSY   <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        oRSP_RESULT <= iALU_RESULT;
                        oRSP_VALID  <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (iRSP_READY) begin
                        oRSP_VALID <= 1'b0;
                        oBUSY      <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    oRSP_VALID <= 1'b0;
                    oBUSY      <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a {A,B} ALU stub
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       req0Valid, req1Valid;
    logic       rdy0, rdy1;
    logic [3:0] req0A, req0B, req0Inst, req1A, req1B, req1Inst;
    logic [3:0] aluA, aluB, aluInst;
    logic [7:0] aluResult;
    logic       rspValid, rspReady, rspId, busy;
    logic [7:0] rspResult;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign aluResult = {aluA, aluB};

    alu_arbiter dut (
        .iCLK        (clk),
        .iRSTn       (rstN),
        .iREQ0_VALID (req0Valid),
        .oREQ0_READY (rdy0),
        .iREQ0_A     (req0A),
        .iREQ0_B     (req0B),
        .iREQ0_INST  (req0Inst),
        .iREQ1_VALID (req1Valid),
        .oREQ1_READY (rdy1),
        .iREQ1_A     (req1A),
        .iREQ1_B     (req1B),
        .iREQ1_INST  (req1Inst),
        .oALU_A      (aluA),
        .oALU_B      (aluB),
        .oALU_INST   (aluInst),
        .iALU_RESULT (aluResult),
        .oRSP_VALID  (rspValid),
        .iRSP_READY  (rspReady),
        .oRSP_ID     (rspId),
        .oRSP_RESULT (rspResult),
        .oBUSY       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idleInputs();
        req0Valid = 0; req0A = 0; req0B = 0; req0Inst = 0;
        req1Valid = 0; req1A = 0; req1B = 0; req1Inst = 0;
    endtask

    task automatic applyReset();
        idleInputs();
        rspReady = 0;
        rstN = 0;
        tick();
        tick();
        rstN = 1;
        #1;
    endtask

    // Presents one command on requester r and returns once it has been taken.
    task automatic sendOp(input int r, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] inst, output bit ok);
        bit hit;
        ok = 0;
        if (r == 0) begin req0A = a; req0B = b; req0Inst = inst; req0Valid = 1; end
        else        begin req1A = a; req1B = b; req1Inst = inst; req1Valid = 1; end
        for (int i = 0; i < 20; i++) begin
            #1;
            hit = (r == 0) ? rdy0 : rdy1;
            tick();
            if (hit) begin ok = 1; break; end
        end
        if (r == 0) req0Valid = 0; else req1Valid = 0;
    endtask

    // Waits for a response, records it and lets the edge consume it.
    task automatic waitRsp(output bit got, output logic id, output logic [7:0] res);
        got = 0; id = 0; res = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (rspValid) begin
                got = 1; id = rspId; res = rspResult;
                tick();
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        idleInputs();
        rspReady = 0;
        rstN = 0;
        req0Valid = 1; req1Valid = 1;
        #1;
        total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL reset_rdy0 got=%0h exp=0", rdy0); end
        total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL reset_rdy1 got=%0h exp=0", rdy1); end
        total++; if (rspValid !== 1'b0) begin bad++; $display("FAIL reset_rspValid got=%0h exp=0", rspValid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        total++; if ({aluA, aluB, aluInst} !== 12'h000) begin bad++; $display("FAIL reset_alu got=%0h exp=0", {aluA, aluB, aluInst}); end
        total++; if ({rspId, rspResult} !== 9'h000) begin bad++; $display("FAIL reset_rsp got=%0h exp=0", {rspId, rspResult}); end
        tick();
        rstN = 1;
        #1;
        // Both valid straight out of reset: requester 0 must win the tie.
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL reset_prio_rdy0 got=%0h exp=1", rdy0); end
        total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL reset_prio_rdy1 got=%0h exp=0", rdy1); end
        req0Valid = 0; req1Valid = 0;
        #1;
        total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL noreq_rdy0 got=%0h exp=0", rdy0); end
    endtask

    task automatic test_single();
        applyReset();
        rspReady = 1;
        req0A = 4'ha; req0B = 4'h6; req0Inst = 4'h0; req0Valid = 1;
        #1;
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL single_rdy0 got=%0h exp=1", rdy0); end
        total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL single_rdy1 got=%0h exp=0", rdy1); end
        tick();
        req0Valid = 0;
        #1;
        total++; if (rspValid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%0h exp=0", rspValid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%0h exp=1", busy); end
        total++; if ({aluA, aluB, aluInst} !== 12'ha60) begin bad++; $display("FAIL single_alu got=%0h exp=a60", {aluA, aluB, aluInst}); end
        tick();
        #1;
        total++; if (rspValid !== 1'b1) begin bad++; $display("FAIL single_valid_t2 got=%0h exp=1", rspValid); end
        total++; if (rspId !== 1'b0) begin bad++; $display("FAIL single_id got=%0h exp=0", rspId); end
        total++; if (rspResult !== 8'ha6) begin bad++; $display("FAIL single_result got=%0h exp=a6", rspResult); end
        tick();
        #1;
        total++; if (rspValid !== 1'b0) begin bad++; $display("FAIL single_valid_drop got=%0h exp=0", rspValid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%0h exp=0", busy); end
    endtask

    task automatic test_round_robin();
        bit got;
        logic id;
        logic [7:0] res;
        applyReset();
        rspReady = 1;
        for (int rep = 0; rep < 2; rep++) begin
            req0A = 4'h3; req0B = 4'h4; req0Inst = 4'h1; req0Valid = 1;
            req1A = 4'h5; req1B = 4'h6; req1Inst = 4'h2; req1Valid = 1;
            #1;
            total++; if ({rdy1, rdy0} !== 2'b01) begin bad++; $display("FAIL rr%0d_first_grant got=%0b exp=01", rep, {rdy1, rdy0}); end
            tick();
            req0Valid = 0;
            waitRsp(got, id, res);
            total++; if ({got, id, res} !== {1'b1, 1'b0, 8'h34}) begin bad++; $display("FAIL rr%0d_rsp0 got=%0b/%0h/%0h exp=1/0/34", rep, got, id, res); end
            #1;
            total++; if ({rdy1, rdy0} !== 2'b10) begin bad++; $display("FAIL rr%0d_second_grant got=%0b exp=10", rep, {rdy1, rdy0}); end
            tick();
            req1Valid = 0;
            waitRsp(got, id, res);
            total++; if ({got, id, res} !== {1'b1, 1'b1, 8'h56}) begin bad++; $display("FAIL rr%0d_rsp1 got=%0b/%0h/%0h exp=1/1/56", rep, got, id, res); end
        end
    endtask

    task automatic test_stall();
        bit ok;
        applyReset();
        rspReady = 0;
        sendOp(0, 4'h7, 4'h9, 4'h2, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL stall_accept got=%0b exp=1", ok); end
        tick();
        req0A = 4'h1; req0Valid = 1;
        req1A = 4'h2; req1Valid = 1;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (rspValid !== 1'b1) begin bad++; $display("FAIL stall%0d_valid got=%0h exp=1", k, rspValid); end
            total++; if ({rspId, rspResult} !== 9'h079) begin bad++; $display("FAIL stall%0d_payload got=%0h exp=079", k, {rspId, rspResult}); end
            total++; if ({rdy1, rdy0} !== 2'b00) begin bad++; $display("FAIL stall%0d_ready got=%0b exp=00", k, {rdy1, rdy0}); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall%0d_busy got=%0h exp=1", k, busy); end
            tick();
        end
        rspReady = 1;
        tick();
        #1;
        // Requester 0 was served last, so requester 1 wins the tie now.
        total++; if ({rdy1, rdy0} !== 2'b10) begin bad++; $display("FAIL stall_next_grant got=%0b exp=10", {rdy1, rdy0}); end
        idleInputs();
    endtask

    task automatic test_back_to_back();
        int acc[$];
        logic [7:0] expQ[$];
        logic [7:0] e;
        int rspCnt;
        applyReset();
        rspReady = 1;
        rspCnt = 0;
        req1A = 4'($urandom); req1B = 4'($urandom); req1Inst = 4'h3; req1Valid = 1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            bit taken;
            #1;
            total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL b2b_c%0d_rdy0 got=%0h exp=0", cyc, rdy0); end
            taken = rdy1 && req1Valid;
            if (taken) begin acc.push_back(cyc); expQ.push_back({req1A, req1B}); end
            if (rspValid) begin
                rspCnt++;
                e = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
                total++; if ({rspId, rspResult} !== {1'b1, e}) begin bad++; $display("FAIL b2b_rsp%0d got=%0h/%0h exp=1/%0h", rspCnt, rspId, rspResult, e); end
            end
            tick();
            if (taken) begin
                req1A = 4'($urandom); req1B = 4'($urandom);
                if (acc.size() == 3) req1Valid = 0;
            end
        end
        total++; if (acc.size() != 3) begin bad++; $display("FAIL b2b_accepts got=%0d exp=3", acc.size()); end
        else begin
            total++; if (acc[1] - acc[0] != 3) begin bad++; $display("FAIL b2b_gap1 got=%0d exp=3", acc[1] - acc[0]); end
            total++; if (acc[2] - acc[1] != 3) begin bad++; $display("FAIL b2b_gap2 got=%0d exp=3", acc[2] - acc[1]); end
        end
        total++; if (rspCnt != 3) begin bad++; $display("FAIL b2b_rsp_count got=%0d exp=3", rspCnt); end
    endtask

    task automatic test_reset_mid();
        bit ok, got;
        logic id;
        logic [7:0] res;
        applyReset();
        rspReady = 1;
        sendOp(0, 4'hc, 4'hd, 4'h5, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL rstmid_accept got=%0b exp=1", ok); end
        rstN = 0;
        req1Valid = 1;
        #1;
        total++; if ({aluA, aluB, aluInst} !== 12'h000) begin bad++; $display("FAIL rstmid_alu got=%0h exp=0", {aluA, aluB, aluInst}); end
        total++; if ({rspValid, rspId, rspResult} !== 10'h000) begin bad++; $display("FAIL rstmid_rsp got=%0h exp=0", {rspValid, rspId, rspResult}); end
        total++; if ({busy, rdy1, rdy0} !== 3'b000) begin bad++; $display("FAIL rstmid_ctrl got=%0b exp=000", {busy, rdy1, rdy0}); end
        req1Valid = 0;
        tick();
        rstN = 1;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if ({rspValid, busy} !== 2'b00) begin bad++; $display("FAIL rstmid_quiet%0d got=%0b exp=00", k, {rspValid, busy}); end
            tick();
        end
        sendOp(0, 4'h2, 4'hb, 4'h7, ok);
        waitRsp(got, id, res);
        total++; if ({ok, got, id, res} !== {1'b1, 1'b1, 1'b0, 8'h2b}) begin bad++; $display("FAIL rstmid_after got=%0b/%0b/%0h/%0h exp=1/1/0/2b", ok, got, id, res); end
    endtask

    task automatic test_inst_sweep();
        bit ok, got;
        logic id;
        logic [7:0] res;
        int nRsp;
        applyReset();
        rspReady = 1;
        nRsp = 0;
        for (int i = 0; i < 16; i++) begin
            sendOp(0, 4'ha, 4'h6, 4'(i), ok);
            total++; if ({ok, aluInst} !== {1'b1, 4'(i)}) begin bad++; $display("FAIL sweep%0d_inst got=%0b/%0h exp=1/%0h", i, ok, aluInst, i); end
            waitRsp(got, id, res);
            if (got) nRsp++;
            total++; if ({got, id, res} !== {1'b1, 1'b0, 8'ha6}) begin bad++; $display("FAIL sweep%0d_rsp got=%0b/%0h/%0h exp=1/0/a6", i, got, id, res); end
        end
        total++; if (nRsp != 16) begin bad++; $display("FAIL sweep_count got=%0d exp=16", nRsp); end
    endtask

    // Random traffic against a cycle-level behavioural model of the arbiter.
    task automatic test_random();
        bit pend[2];
        logic [3:0] pa[2], pb[2], pi[2];
        bit inflight, anyOp, prefer1, expValid;
        int due;
        logic expId;
        logic [3:0] eA, eB, eI;
        bit g0, g1;
        int r;
        applyReset();
        inflight = 0; anyOp = 0; prefer1 = 0; due = 0; expId = 0;
        eA = 0; eB = 0; eI = 0;
        for (int k = 0; k < 2; k++) begin pend[k] = 0; pa[k] = 0; pb[k] = 0; pi[k] = 0; end
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && $urandom_range(2) == 0) begin
                    pend[k] = 1; pa[k] = 4'($urandom); pb[k] = 4'($urandom); pi[k] = 4'($urandom);
                end
            end
            req0Valid = pend[0]; req0A = pa[0]; req0B = pb[0]; req0Inst = pi[0];
            req1Valid = pend[1]; req1A = pa[1]; req1B = pb[1]; req1Inst = pi[1];
            rspReady = 1'($urandom_range(1));
            #1;
            g0 = 0; g1 = 0;
            if (!inflight) begin
                if (pend[0] && pend[1]) begin g1 = prefer1; g0 = !prefer1; end
                else begin g0 = pend[0]; g1 = pend[1]; end
            end
            expValid = inflight && (n >= due);
            total++; if ({rdy1, rdy0} !== {g1, g0}) begin bad++; $display("FAIL rand%0d_ready got=%0b exp=%0b", n, {rdy1, rdy0}, {g1, g0}); end
            total++; if ({rspValid, busy} !== {expValid, inflight}) begin bad++; $display("FAIL rand%0d_valid_busy got=%0b exp=%0b", n, {rspValid, busy}, {expValid, inflight}); end
            if (anyOp) begin
                total++; if ({aluA, aluB, aluInst} !== {eA, eB, eI}) begin bad++; $display("FAIL rand%0d_alu got=%0h exp=%0h", n, {aluA, aluB, aluInst}, {eA, eB, eI}); end
            end
            if (expValid) begin
                total++; if ({rspId, rspResult} !== {expId, eA, eB}) begin bad++; $display("FAIL rand%0d_rsp got=%0h/%0h exp=%0h/%0h", n, rspId, rspResult, expId, {eA, eB}); end
                if (rspReady) inflight = 0;
            end
            if (g0 || g1) begin
                r = g1 ? 1 : 0;
                inflight = 1; anyOp = 1; due = n + 2;
                expId = g1; eA = pa[r]; eB = pb[r]; eI = pi[r];
                prefer1 = !g1;
                pend[r] = 0;
            end
            tick();
        end
        idleInputs();
    endtask

    initial begin
        idleInputs();
        rspReady = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_inst_sweep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
